rwt_axis_escape_inserter: RTL
=============================

Name: rwt_axis_escape_inserter

Overview:
- Streaming encoder that turns a 32-bit AXIS stream with a per-sample tag sideband (tuser) into a flat escaped 32-bit AXIS stream.
- Output follows the same escape convention as the tagged/escaped file sinks and sources used in simulation.
- Sits directly upstream of any escaped-stream consumer, e.g. a DMA or an escaped file sink.
- Inserts an escape prefix before tagged samples and before literal data words equal to the escape word.

Parameters:
- ESCAPE, 32'hAAAAAAAA, escape word; bit 31 must be 1 (elaboration-time assertion).
- UWIDTH, 2, width of the input tag sideband; legal range 1..31.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- s_axis_tdata  input  32  input sample
- s_axis_tuser  input  UWIDTH  tag; nonzero marks a tagged sample
- s_axis_tlast  input  1  end of packet
- s_axis_tvalid  input  1  input valid
- s_axis_tready  output  1  input ready
- m_axis_tdata  output  32  escaped output word
- m_axis_tlast  output  1  end of packet, on the final word of an encoded sample
- m_axis_tvalid  output  1  output valid
- m_axis_tready  input  1  output ready
- tag_count  output  32  tagged samples encoded; saturates at 32'hFFFFFFFF
- esc_count  output  32  literal escapes encoded; saturates at 32'hFFFFFFFF

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0, state PASS, holding register cleared. Reset mid-sequence discards any partially emitted sample; there is no recovery.
- Output register: single registered output stage. "Slot free" means !m_axis_tvalid || m_axis_tready.
- Input ready: s_axis_tready = (state == PASS) && slot_free. This is combinational from m_axis_tready; there is no combinational path from s_* to m_*.
- Latency: 1 cycle from input acceptance to the first output word being valid.
- Encoding, per accepted sample (d, u, l):
  - u != 0: emit ESCAPE (tlast=0), then tag word {1'b0, (31-UWIDTH)'b0, u} (tlast=0), then d (tlast=l).
  - u == 0 and d == ESCAPE: emit ESCAPE (tlast=0), then d (tlast=l).
  - otherwise: emit d (tlast=l).
- The tag word always has bit 31 = 0, so it never equals ESCAPE. The decoder rule is: ESCAPE followed by ESCAPE = literal; ESCAPE followed by any other word = tag word, next word = data.
- State machine (transitions occur only when slot free):
  - PASS, input fires:
    - tagged: load ESCAPE, latch d/u/l, go TAG.
    - literal escape: load ESCAPE, latch d/l, go DATA.
    - else: load d/l, stay PASS.
  - PASS, no input fire: m_axis_tvalid <= 0 if m_axis_tready, else hold.
  - TAG: load tag word, go DATA.
  - DATA: load latched d with tlast = latched l, go PASS.
- Backpressure: m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid && !m_axis_tready.
- Throughput:
  - Untagged, non-escape stream: 1 word/cycle sustained.
  - Literal escape: 2 cycles.
  - Tagged sample: 3 cycles.
- Counters: tag_count increments when a tagged sample is accepted; esc_count increments when a literal escape is accepted. Both saturate rather than wrap.
- Idle: a tagged sample with tlast=1 ends the packet on the data word only, never on the ESCAPE or tag word.

Decomposition:
- Package rwt_escape_pkg:
  - state enum {PASS, TAG, DATA}
  - default ESCAPE constant
  - function make_tag_word(u)
  - function is_escape(d)
- No sub-module; a single always_ff plus counters.

Test Plan:
- Untagged stream 0..19, tlast on 19, m_axis_tready=1 -> identical 20 words, tlast on 19, one word per cycle, first word 1 cycle after first accept.
- Single sample d=32'hAAAAAAAA, u=0, l=1 -> output AAAAAAAA (tlast=0), AAAAAAAA (tlast=1); esc_count=1.
- Sample d=32'h12345678, u=2'b10, l=1 -> output AAAAAAAA, 00000002, 12345678 (tlast only on last); tag_count=1; s_axis_tready low for 2 cycles.
- Tagged sample with m_axis_tready toggling every other cycle -> same 3-word sequence; data stable while stalled; no dropped or duplicated words.
- reset pulsed while in TAG state -> next cycle: m_axis_tvalid=0, counters=0, s_axis_tready=1 once the slot is free; a fresh sample encodes correctly.
- 10 random packets (mixed tags and escapes) fed back through a behavioural decoder -> original data/tuser/tlast recovered exactly; counters match the stimulus tallies.

Source files
------------

// File: rtl/rwt_axis_escape_inserter_pkg.sv
// Shared types and helpers for the escaped-stream encoder: FSM states,
// the default escape word and the tag-word / escape-match helpers.
package rwt_escape_pkg;

   typedef enum logic [1:0] {
      PASS = 2'd0,
      TAG  = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_ESCAPE = 32'hAAAAAAAA;

   // Bit 31 is forced low so a tag word can never be mistaken for ESCAPE.
   function automatic logic [31:0] make_tag_word(input logic [30:0] u);
      return {1'b0, u};
   endfunction

   function automatic logic is_escape(input logic [31:0] d, input logic [31:0] esc);
      return (d == esc);
   endfunction

endpackage

// File: rtl/rwt_axis_escape_inserter.sv
// Encodes a tagged 32-bit AXIS stream into a flat escaped stream: ESCAPE+tag+data
// for tagged samples, ESCAPE+ESCAPE for literal escapes, plain data otherwise.
module rwt_axis_escape_inserter
   import rwt_escape_pkg::*;
#(
   parameter logic [31:0] ESCAPE = DEFAULT_ESCAPE,
   parameter int          UWIDTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       s_axis_tdata,
   input  logic [UWIDTH-1:0] s_axis_tuser,
   input  logic              s_axis_tlast,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [31:0]       m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [31:0]       tag_count,
   output logic [31:0]       esc_count
);

   if (ESCAPE[31] != 1'b1) begin : g_bad_escape
      $error("ESCAPE must have bit 31 set");
   end
   if (UWIDTH < 1 || UWIDTH > 31) begin : g_bad_uwidth
      $error("UWIDTH must be in 1..31");
   end

   state_t            state;
   logic [31:0]       d_q;
   logic [UWIDTH-1:0] u_q;
   logic              l_q;

   logic slot_free;
   logic fire;
   logic in_tagged;
   logic in_literal;

   // Valid/ready: a beat transfers on a cycle where valid and ready are both high;
   // the output word and tlast never change while valid is high and ready is low.
   assign slot_free     = !m_axis_tvalid || m_axis_tready;
   assign s_axis_tready = (state == PASS) && slot_free;
   assign fire          = s_axis_tvalid && s_axis_tready;
   assign in_tagged     = (s_axis_tuser != '0);
   assign in_literal    = !in_tagged && is_escape(s_axis_tdata, ESCAPE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= PASS;
         d_q           <= '0;
         u_q           <= '0;
         l_q           <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else if (slot_free) begin
         case (state)
            PASS: begin
               if (fire) begin
                  m_axis_tvalid <= 1'b1;
                  d_q           <= s_axis_tdata;
                  u_q           <= s_axis_tuser;
                  l_q           <= s_axis_tlast;
                  if (in_tagged) begin
                     m_axis_tdata <= ESCAPE;
                     m_axis_tlast <= 1'b0;
                     state        <= TAG;
                  end else if (in_literal) begin
                     m_axis_tdata <= ESCAPE;
                     m_axis_tlast <= 1'b0;
                     state        <= DATA;
                  end else begin
                     m_axis_tdata <= s_axis_tdata;
                     m_axis_tlast <= s_axis_tlast;
                  end
               end else begin
                  // slot_free with valid high implies ready, so the word just left
                  m_axis_tvalid <= 1'b0;
               end
            end
            TAG: begin
               m_axis_tdata  <= make_tag_word(31'(u_q));
               m_axis_tlast  <= 1'b0;
               m_axis_tvalid <= 1'b1;
               state         <= DATA;
            end
            DATA: begin
               m_axis_tdata  <= d_q;
               m_axis_tlast  <= l_q;
               m_axis_tvalid <= 1'b1;
               state         <= PASS;
            end
            default: state <= PASS;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_count <= '0;
         esc_count <= '0;
      end else if (fire) begin
         if (in_tagged && tag_count != 32'hFFFFFFFF) tag_count <= tag_count + 32'd1;
         if (in_literal && esc_count != 32'hFFFFFFFF) esc_count <= esc_count + 32'd1;
      end
   end

endmodule
